pl_spi_slave: RTL and testbench
===============================

PL_SPI_SLAVE -- requirements
Module: pl_spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops in each SPI input synchronizer; legal values 2..3.
REQ-002 Parameter DEVICE_ID, default 8'hA5: value of read-only register 0.
REQ-003 i_Clk  in  1  system clock; the only clock, all logic on its rising edge.
REQ-004 i_Rst_n  in  1  reset; synchronous, active-low.
REQ-005 i_SPI_Clk  in  1  SPI SCLK from master; asynchronous; mode 0 (CPOL=0, CPHA=0).
REQ-006 i_SPI_CS  in  1  chip select from master; active-low; asynchronous.
REQ-007 i_SPI_MOSI  in  1  serial data from master, MSB first.
REQ-008 o_SPI_MISO  out  1  serial data to master, MSB first.
REQ-009 o_SPI_MISO_En  out  1  MISO drive enable; high exactly while synchronized CS is low.
REQ-010 i_Host_Addr  in  4  host read/write address into the 16x8 register file.
REQ-011 o_Host_Data  out  8  combinational read of reg[i_Host_Addr].
REQ-012 i_Host_Wr  in  1  host write enable, one cycle per write.
REQ-013 i_Host_Wr_Data  in  8  host write data.
REQ-014 o_Wr_Strobe  out  1  one-cycle pulse per SPI-originated register write.
REQ-015 o_Wr_Addr  out  4  address of the SPI write; valid with o_Wr_Strobe.
REQ-016 o_Wr_Data  out  8  data of the SPI write; valid with o_Wr_Strobe.
REQ-017 o_Frame_Done  out  1  one-cycle pulse on each synchronized CS rising edge.
REQ-018 o_Frame_Cnt  out  8  count of completed frames; wraps 255 -> 0.

Function
REQ-019 SCLK, CS and MOSI SHALL each pass through a SYNC_STAGES flip-flop synchronizer; SCLK/CS edges are detected from the last stage and its one-cycle-delayed copy.
REQ-020 Operating constraint: SCLK high and low times >= SYNC_STAGES+3 i_Clk cycles (the master's 10-cycle half-bit satisfies this).
REQ-021 States SHALL be IDLE, CMD, WR_DATA, RD_DATA; IDLE -> CMD on a CS falling edge only; any state -> IDLE on a CS rising edge.
REQ-022 MOSI SHALL be sampled on each detected SCLK rising edge while CS is low; a bit counter (0..7) marks byte completion on the 8th sample.
REQ-023 CMD: the first byte is {RW, A6..A0}; RW=1 selects RD_DATA, RW=0 selects WR_DATA; the address pointer loads A3..A0; A6..A4 SHALL be ignored.
REQ-024 WR_DATA: each completed byte SHALL be written to reg[ptr], pulse o_Wr_Strobe with ptr/data the next cycle, then ptr increments modulo 16 (15 -> 0).
REQ-025 SPI writes to address 0 SHALL be discarded (no strobe) but ptr still increments; reg 0 always reads DEVICE_ID.
REQ-026 RD_DATA: each data byte SHALL be reg[ptr] captured on the SCLK falling edge following the previous byte's 8th rising edge; ptr then increments modulo 16.
REQ-027 MISO: on a CS falling edge the tx shift register SHALL load o_Frame_Cnt and drive its MSB; every SCLK falling edge shifts the next bit; after 8 bits the next byte loads (reg data in RD_DATA, 8'h00 in WR_DATA).
REQ-028 CS rising mid-byte: the partial byte SHALL be discarded (no write, no strobe), bit counter cleared, o_Frame_Done still pulses, o_Frame_Cnt still increments.
REQ-029 Host write SHALL update reg[i_Host_Addr] in one cycle (addr 0 ignored); on same-cycle host and SPI write to the same address, the SPI write wins.
REQ-030 Frames shorter than one full command byte SHALL cause no register access.
REQ-031 While CS is high o_SPI_MISO SHALL be 0.

Reset
REQ-032 With i_Rst_n low at a clock edge: state IDLE, regs 1..15 = 8'h00, ptr = 0, bit counter = 0, o_Frame_Cnt = 0, o_Wr_Strobe = 0, o_Frame_Done = 0, o_SPI_MISO = 0, synchronizers = CS high, SCLK low.
REQ-033 Reset during a frame: the rest of that frame SHALL be ignored; the next CS falling edge starts a new frame.

Verification
REQ-034 Write frame: CS low, send 8'h03, 8'h5A, 8'hC3, CS high -> strobes (3,5A) then (4,C3); o_Host_Data at addr 4 = C3; o_Frame_Cnt = 1.
REQ-035 Read frame: preload regs 3,4 via host = 11,22; send 8'h83, 8'h00, 8'h00 -> MISO bytes = Frame_Cnt, 11, 22; no strobes.
REQ-036 Wrap/ID: write frame 8'h0F, AA, BB -> reg15 = AA, reg0 stays A5, no strobe for addr 0; read 8'h8F x3 -> AA, A5.
REQ-037 Abort: send 8'h02, then 5 bits of 8'hFF, CS high -> no strobe, reg2 unchanged, one o_Frame_Done pulse.
REQ-038 Reset mid-frame: assert i_Rst_n low after command byte 8'h05 for 1 cycle, continue sending 8'h77 -> no write; next full frame works normally.
REQ-039 Collision: host writes addr 6 = 8'h10 in the same cycle as SPI write of addr 6 = 8'h20 -> reg6 = 8'h20.

Source files
------------

// File: rtl/pl_spi_slave_if.sv
// pl_spi_slave_if: SPI pins, host register port and status outputs of the SPI slave
interface pl_spi_slave_if;
  logic       i_SPI_Clk;
  logic       i_SPI_CS;
  logic       i_SPI_MOSI;
  logic       o_SPI_MISO;
  logic       o_SPI_MISO_En;
  logic [3:0] i_Host_Addr;
  logic [7:0] o_Host_Data;
  logic       i_Host_Wr;
  logic [7:0] i_Host_Wr_Data;
  logic       o_Wr_Strobe;
  logic [3:0] o_Wr_Addr;
  logic [7:0] o_Wr_Data;
  logic       o_Frame_Done;
  logic [7:0] o_Frame_Cnt;
  modport slave (
    input  i_SPI_Clk, i_SPI_CS, i_SPI_MOSI, i_Host_Addr, i_Host_Wr, i_Host_Wr_Data,
    output o_SPI_MISO, o_SPI_MISO_En, o_Host_Data, o_Wr_Strobe, o_Wr_Addr, o_Wr_Data,
           o_Frame_Done, o_Frame_Cnt
  );
  modport master (
    output i_SPI_Clk, i_SPI_CS, i_SPI_MOSI, i_Host_Addr, i_Host_Wr, i_Host_Wr_Data,
    input  o_SPI_MISO, o_SPI_MISO_En, o_Host_Data, o_Wr_Strobe, o_Wr_Addr, o_Wr_Data,
           o_Frame_Done, o_Frame_Cnt
  );
endinterface

// File: rtl/pl_spi_slave.sv
// pl_spi_slave: mode-0 SPI slave with synchronized inputs and a 16x8 register file
module pl_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVICE_ID   = 8'hA5
) (
  input logic           i_Clk,
  input logic           i_Rst_n,
  pl_spi_slave_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_t;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic       sclk_dly_q, sclk_dly_d, cs_dly_q, cs_dly_d;
  logic [2:0] settle_q, settle_d, bit_q, bit_d;
  state_t     state_q, state_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, wd_q, wd_d, fcnt_q, fcnt_d;
  logic       ld_q, ld_d, stb_q, stb_d, fd_q, fd_d;
  logic [3:0] ptr_q, ptr_d, wa_q, wa_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic       sclk_s, cs_s, mosi_s, settled, cs_fall, cs_rise, sck_rise, sck_fall;
  logic [7:0] rx_n, rd_val;
  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  // edges are ignored until the synchronizers have flushed their reset value, so a
  // reset in the middle of a frame cannot fake a CS falling edge
  assign settled  = settle_q == 3'(SYNC_STAGES + 1);
  assign cs_fall  = settled & cs_dly_q & ~cs_s;
  assign cs_rise  = settled & ~cs_dly_q & cs_s;
  assign sck_rise = ~sclk_dly_q & sclk_s & ~cs_s;
  assign sck_fall = sclk_dly_q & ~sclk_s & ~cs_s;
  assign rx_n     = {rx_q[6:0], mosi_s};
  assign rd_val   = ptr_q == 4'd0 ? DEVICE_ID : regs_q[ptr_q];
  assign bus.o_Host_Data   = bus.i_Host_Addr == 4'd0 ? DEVICE_ID : regs_q[bus.i_Host_Addr];
  assign bus.o_SPI_MISO    = tx_q[7] & ~cs_s;
  assign bus.o_SPI_MISO_En = ~cs_s;
  assign bus.o_Wr_Strobe   = stb_q;
  assign bus.o_Wr_Addr     = wa_q;
  assign bus.o_Wr_Data     = wd_q;
  assign bus.o_Frame_Done  = fd_q;
  assign bus.o_Frame_Cnt   = fcnt_q;
  // next-state: synchronizers, frame FSM, shift registers and register file
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.i_SPI_Clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.i_SPI_CS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_s;
    settle_d    = settled ? settle_q : settle_q + 3'd1;
    state_d     = state_q;
    bit_d       = bit_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ld_d        = ld_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    stb_d       = 1'b0;
    wa_d        = wa_q;
    wd_d        = wd_q;
    fd_d        = cs_rise;
    fcnt_d      = fcnt_q + {7'd0, cs_rise};
    if (bus.i_Host_Wr && bus.i_Host_Addr != 4'd0) regs_d[bus.i_Host_Addr] = bus.i_Host_Wr_Data;
    if (cs_rise) begin
      state_d = IDLE;
      bit_d   = 3'd0;
      ld_d    = 1'b0;
      tx_d    = 8'h00;
    end else if (cs_fall && state_q == IDLE) begin
      state_d = CMD;
      bit_d   = 3'd0;
      ld_d    = 1'b0;
      tx_d    = fcnt_q;
    end else if (state_q != IDLE) begin
      if (sck_rise) begin
        rx_d  = rx_n;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          ld_d = 1'b1;
          if (state_q == CMD) begin
            ptr_d   = rx_n[3:0];
            state_d = rx_n[7] ? RD_DATA : WR_DATA;
          end else if (state_q == WR_DATA) begin
            if (ptr_q != 4'd0) begin
              regs_d[ptr_q] = rx_n;
              stb_d         = 1'b1;
              wa_d          = ptr_q;
              wd_d          = rx_n;
            end
            ptr_d = ptr_q + 4'd1;
          end
        end
      end
      if (sck_fall) begin
        ld_d  = 1'b0;
        tx_d  = ld_q ? (state_q == RD_DATA ? rd_val : 8'h00) : {tx_q[6:0], 1'b0};
        ptr_d = (ld_q && state_q == RD_DATA) ? ptr_q + 4'd1 : ptr_d;
      end
    end
  end
  // state register with synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      settle_q    <= 3'd0;
      state_q     <= IDLE;
      bit_q       <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      ld_q        <= 1'b0;
      ptr_q       <= 4'd0;
      regs_q      <= '{default: 8'h00};
      stb_q       <= 1'b0;
      wa_q        <= 4'd0;
      wd_q        <= 8'h00;
      fd_q        <= 1'b0;
      fcnt_q      <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
      settle_q    <= settle_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ld_q        <= ld_d;
      ptr_q       <= ptr_d;
      regs_q      <= regs_d;
      stb_q       <= stb_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      fd_q        <= fd_d;
      fcnt_q      <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_pl_spi_slave.sv
// tb_pl_spi_slave: randomized scoreboard bench for the SPI slave against a byte-level model
module tb_pl_spi_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pl_spi_slave_if bus();
  pl_spi_slave #(.SYNC_STAGES(2), .DEVICE_ID(8'hA5)) dut (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus));
  int errs = 0;
  int checks = 0;
  logic [7:0] mreg [16];
  logic [7:0] mcnt;
  logic [3:0] mptr;
  int mode;
  int nb;
  logic coll = 1'b0;
  logic [11:0] exp_wr[$];
  logic [7:0] exp_rx[$];
  logic [7:0] act_rx[$];
  logic [7:0] exp_fd[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] mread(input logic [3:0] a);
    return a == 4'd0 ? 8'hA5 : mreg[a];
  endfunction
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (coll && bus.o_Wr_Strobe) begin
        bus.i_Host_Wr = 1'b0;
        coll = 1'b0;
      end
    end
  endtask
  task automatic bit_x(input logic b, output logic r);
    bus.i_SPI_MOSI = b;
    cyc(10);
    bus.i_SPI_Clk = 1'b1;
    r = bus.o_SPI_MISO;
    cyc(10);
    bus.i_SPI_Clk = 1'b0;
  endtask
  task automatic raw(input logic [7:0] b, input int n);
    logic x;
    for (int i = 7; i > 7 - n; i--) bit_x(b[i], x);
  endtask
  task automatic send(input logic [7:0] b, input bit chk_rx);
    logic [7:0] e, r;
    logic x;
    e = nb == 0 ? mcnt : (mode == 3 ? mread(mptr) : 8'h00);
    if (nb == 0) begin
      mode = b[7] ? 3 : 2;
      mptr = b[3:0];
    end else if (mode == 3) begin
      mptr++;
    end else begin
      if (mptr != 4'd0) begin
        mreg[mptr] = b;
        exp_wr.push_back({mptr, b});
      end
      mptr++;
    end
    nb++;
    if (chk_rx) exp_rx.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      bit_x(b[i], x);
      r[i] = x;
    end
    if (chk_rx) act_rx.push_back(r);
  endtask
  task automatic cs_lo();
    bus.i_SPI_CS = 1'b0;
    nb = 0;
    mode = 0;
  endtask
  task automatic cs_hi();
    cyc(10);
    bus.i_SPI_CS = 1'b1;
    mcnt++;
    exp_fd.push_back(mcnt);
    cyc(20);
  endtask
  task automatic hw(input logic [3:0] a, input logic [7:0] d);
    bus.i_Host_Addr = a;
    bus.i_Host_Wr_Data = d;
    bus.i_Host_Wr = 1'b1;
    cyc(1);
    bus.i_Host_Wr = 1'b0;
    if (a != 4'd0) mreg[a] = d;
  endtask
  task automatic hchk(input logic [3:0] a);
    bus.i_Host_Addr = a;
    #1;
    chk($sformatf("host_data[%0d]", a), bus.o_Host_Data, mread(a));
  endtask
  // monitor: strobes, frame-done pulses and received MISO bytes against the scoreboard
  always @(negedge clk) begin
    if (bus.o_Wr_Strobe) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL wr_strobe: unexpected addr=%0h data=%0h", bus.o_Wr_Addr, bus.o_Wr_Data);
      end else chk("wr_strobe", {bus.o_Wr_Addr, bus.o_Wr_Data}, exp_wr.pop_front());
    end
    if (bus.o_Frame_Done) begin
      if (exp_fd.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL frame_done: unexpected cnt=%0h", bus.o_Frame_Cnt);
      end else chk("frame_cnt", bus.o_Frame_Cnt, exp_fd.pop_front());
    end
    if (act_rx.size() > 0) chk("miso_byte", act_rx.pop_front(), exp_rx.pop_front());
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int k;
    bus.i_SPI_Clk = 1'b0;
    bus.i_SPI_CS = 1'b1;
    bus.i_SPI_MOSI = 1'b0;
    bus.i_Host_Addr = 4'd0;
    bus.i_Host_Wr = 1'b0;
    bus.i_Host_Wr_Data = 8'h00;
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    mcnt = 8'h00;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk("rst_miso", bus.o_SPI_MISO, 0);
    chk("rst_miso_en", bus.o_SPI_MISO_En, 0);
    chk("rst_frame_cnt", bus.o_Frame_Cnt, 0);
    chk("rst_strobe", bus.o_Wr_Strobe, 0);
    chk("rst_frame_done", bus.o_Frame_Done, 0);
    hchk(0);
    hchk(1);
    cs_lo();
    cyc(5);
    chk("miso_en_low", bus.o_SPI_MISO_En, 1);
    send(8'h03, 1); send(8'h5A, 1); send(8'hC3, 1);
    cs_hi();
    hchk(3);
    hchk(4);
    chk("frame_cnt_1", bus.o_Frame_Cnt, 1);
    chk("miso_idle", bus.o_SPI_MISO, 0);
    hw(4'd3, 8'h11);
    hw(4'd4, 8'h22);
    cs_lo(); send(8'h83, 1); send(8'h00, 1); send(8'h00, 1); cs_hi();
    cs_lo(); send(8'h0F, 1); send(8'hAA, 1); send(8'hBB, 1); cs_hi();
    hchk(15);
    hchk(0);
    cs_lo(); send(8'h8F, 1); send(8'h00, 1); send(8'h00, 1); cs_hi();
    cs_lo(); send(8'h02, 1); raw(8'hFF, 5); cs_hi();
    hchk(2);
    cs_lo();
    send(8'h05, 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    mcnt = 8'h00;
    raw(8'h77, 8);
    cs_hi();
    hchk(5);
    cs_lo(); send(8'h05, 1); send(8'h77, 1); cs_hi();
    hchk(5);
    cs_lo();
    send(8'h06, 1);
    bus.i_Host_Addr = 4'd6;
    bus.i_Host_Wr_Data = 8'h10;
    bus.i_Host_Wr = 1'b1;
    coll = 1'b1;
    mreg[6] = 8'h10;
    send(8'h20, 1);
    chk("collision_seen", coll, 0);
    bus.i_Host_Wr = 1'b0;
    coll = 1'b0;
    cs_hi();
    hchk(6);
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 2)) hw(4'($urandom), 8'($urandom));
      k = $urandom_range(0, 4);
      cs_lo();
      if (k == 0) raw(8'($urandom), $urandom_range(0, 7));
      else begin
        send(8'($urandom), 1);
        for (int j = 1; j < k; j++) send(8'($urandom), 1);
        if ($urandom_range(0, 3) == 0) raw(8'($urandom), $urandom_range(1, 7));
      end
      cs_hi();
    end
    for (int a = 0; a < 16; a++) hchk(4'(a));
    cyc(20);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("fd_queue_empty", exp_fd.size(), 0);
    chk("rx_queue_empty", exp_rx.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
